// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: Avalon-MM master sequencer for single load/store requests.
// Each accepted start becomes at most one word-aligned bus transaction. The
// block drives lane enables and lane-shifted write data, stalls on waitrequest
// and aligns the returned read data into a sign/zero-extended or LWL/LWR-merged
// result.
//
// Handshake: a bus request is offered while read or write is high. It is
// accepted at the first clock edge with waitrequest low. address, byteenable
// and writedata stay constant for the whole offer. readdata is sampled one
// cycle after the accepting edge. start is sampled only when the controller
// is idle or in its completion cycle.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  instcode,
  input  logic [31:0] addr,
  input  logic [31:0] storedata,
  input  logic [31:0] rtold,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] loaddata,
  output logic        misaligned,
  output logic        timeout
);

  localparam logic [6:0] OP_LB  = 7'd42;
  localparam logic [6:0] OP_LBU = 7'd43;
  localparam logic [6:0] OP_LH  = 7'd44;
  localparam logic [6:0] OP_LHU = 7'd45;
  localparam logic [6:0] OP_LW  = 7'd47;
  localparam logic [6:0] OP_LWL = 7'd48;
  localparam logic [6:0] OP_LWR = 7'd49;
  localparam logic [6:0] OP_SB  = 7'd50;
  localparam logic [6:0] OP_SH  = 7'd51;
  localparam logic [6:0] OP_SW  = 7'd52;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RDATA = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONMEM   = 2'd0,
    CLS_MISALIGN = 2'd1,
    CLS_LOAD     = 2'd2,
    CLS_STORE    = 2'd3
  } cls_t;

  // Sorts a request into bus load, bus store, misaligned or non-memory.
  function automatic cls_t classify(input logic [6:0] op, input logic [1:0] o);
    cls_t c;
    case (op)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: c = CLS_LOAD;
      OP_LH, OP_LHU:                 c = o[0] ? CLS_MISALIGN : CLS_LOAD;
      OP_LW:                         c = (o != 2'b00) ? CLS_MISALIGN : CLS_LOAD;
      OP_SB:                         c = CLS_STORE;
      OP_SH:                         c = o[0] ? CLS_MISALIGN : CLS_STORE;
      OP_SW:                         c = (o != 2'b00) ? CLS_MISALIGN : CLS_STORE;
      default:                       c = CLS_NONMEM;
    endcase
    return c;
  endfunction

  state_t      state;
  state_t      state_nxt;
  cls_t        cls_in;
  logic        accept;
  logic        timeout_hit;
  logic [31:0] stall_cnt;

  // Request fields latched at the accepting edge.
  logic [6:0]  op_q;
  logic [1:0]  off_q;
  logic [29:0] word_q;
  logic [31:0] sdata_q;
  logic [31:0] rtold_q;
  logic        load_q;
  logic        mis_q;
  logic        tmo_q;
  logic [31:0] loaddata_q;

  // Lane data derived from the latched request.
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] aligned;

  assign cls_in = classify(instcode, addr[1:0]);
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // The stall that would make the count reach TIMEOUT ends the offer.
  assign timeout_hit = (TIMEOUT != 0) && waitrequest &&
                       (stall_cnt == TIMEOUT - 32'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if ((cls_in == CLS_LOAD) || (cls_in == CLS_STORE)) state_nxt = ST_REQ;
          else                                               state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!waitrequest)     state_nxt = load_q ? ST_RDATA : ST_DONE;
        else if (timeout_hit) state_nxt = ST_DONE;
        else                  state_nxt = ST_REQ;
      end
      ST_RDATA: state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bus and status outputs decoded from state and latched request.
  always_comb begin
    read       = (state == ST_REQ) && load_q;
    write      = (state == ST_REQ) && !load_q;
    busy       = (state == ST_REQ) || (state == ST_RDATA);
    done       = (state == ST_DONE);
    byteenable = (state == ST_REQ) ? be_calc : 4'b0000;
    misaligned = (state == ST_DONE) && mis_q;
    timeout    = (state == ST_DONE) && tmo_q;
  end

  assign address   = {word_q, 2'b00};
  assign writedata = wdata_calc;
  assign loaddata  = loaddata_q;

  // Request capture, stall counting and load result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 7'd0;
      off_q      <= 2'd0;
      word_q     <= 30'd0;
      sdata_q    <= 32'd0;
      rtold_q    <= 32'd0;
      load_q     <= 1'b0;
      mis_q      <= 1'b0;
      tmo_q      <= 1'b0;
      stall_cnt  <= 32'd0;
      loaddata_q <= 32'd0;
    end else begin
      if (accept) begin
        op_q      <= instcode;
        off_q     <= addr[1:0];
        word_q    <= addr[31:2];
        sdata_q   <= storedata;
        rtold_q   <= rtold;
        load_q    <= (cls_in == CLS_LOAD);
        mis_q     <= (cls_in == CLS_MISALIGN);
        tmo_q     <= 1'b0;
        stall_cnt <= 32'd0;
      end else if ((state == ST_REQ) && waitrequest) begin
        if (TIMEOUT != 0) stall_cnt <= stall_cnt + 32'd1;
        if (timeout_hit)  tmo_q <= 1'b1;
      end
      if (state == ST_RDATA) loaddata_q <= aligned;
    end
  end

  // Lane enables for the latched access size and offset.
  always_comb begin
    case (op_q)
      OP_LB, OP_LBU, OP_SB: be_calc = 4'b0001 << off_q;
      OP_LH, OP_LHU, OP_SH: be_calc = off_q[1] ? 4'b1100 : 4'b0011;
      default:              be_calc = 4'b1111;
    endcase
  end

  // Store data moved into its byte lanes; unused lanes read as zero.
  always_comb begin
    case (op_q)
      OP_SB:   wdata_calc = {24'd0, sdata_q[7:0]} << {off_q, 3'b000};
      OP_SH:   wdata_calc = off_q[1] ? {sdata_q[15:0], 16'd0} : {16'd0, sdata_q[15:0]};
      OP_SW:   wdata_calc = sdata_q;
      default: wdata_calc = 32'd0;
    endcase
  end

  // Read data alignment, extension and LWL/LWR merge with the old rt value.
  always_comb begin
    rd_byte = readdata[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? readdata[31:16] : readdata[15:0];
    case (op_q)
      OP_LB:  aligned = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU: aligned = {24'd0, rd_byte};
      OP_LH:  aligned = {{16{rd_half[15]}}, rd_half};
      OP_LHU: aligned = {16'd0, rd_half};
      OP_LW:  aligned = readdata;
      OP_LWL: begin
        case (off_q)
          2'd0:    aligned = {readdata[7:0],  rtold_q[23:0]};
          2'd1:    aligned = {readdata[15:0], rtold_q[15:0]};
          2'd2:    aligned = {readdata[23:0], rtold_q[7:0]};
          default: aligned = readdata;
        endcase
      end
      OP_LWR: begin
        case (off_q)
          2'd0:    aligned = readdata;
          2'd1:    aligned = {rtold_q[31:24], readdata[31:8]};
          2'd2:    aligned = {rtold_q[31:16], readdata[31:16]};
          default: aligned = {rtold_q[31:8],  readdata[31:24]};
        endcase
      end
      default: aligned = readdata;
    endcase
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Avalon-MM master sequencer directly downstream of the memory-access decode unit (mxu). It accepts one load/store request per start pulse and turns it into a single word-aligned bus transaction. It generates lane byteenables and shifted write data, stalls on waitrequest, and captures and aligns read data. It returns a sign/zero-extended or LWL/LWR-merged load result with a done pulse, for consumption by the execute/writeback control.

Parameters:
TIMEOUT, 0, consecutive waitrequest cycles tolerated in REQ before abort; 0 = never abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  request strobe; sampled only in IDLE or DONE
instcode  in  7  LB=42 LBU=43 LH=44 LHU=45 LUI=46 LW=47 LWL=48 LWR=49 SB=50 SH=51 SW=52; others = non-memory
addr  in  32  effective byte address
storedata  in  32  rt value for stores
rtold  in  32  current rt value for LWL/LWR merge
address  out  32  bus word address, {addr[31:2],2'b00}
read  out  1  bus read
write  out  1  bus write
byteenable  out  4  bus lane enables
writedata  out  32  bus write data
waitrequest  in  1  bus stall
readdata  in  32  bus read data, valid the cycle after the accepting cycle
busy  out  1  state is REQ or RDATA
done  out  1  one-cycle completion pulse
loaddata  out  32  aligned load result, held until next accepted start
misaligned  out  1  valid with done; request rejected, no bus access
timeout  out  1  valid with done; transaction aborted

Behaviour:
- FSM states: IDLE, REQ, RDATA, DONE. Reset: state IDLE. All outputs 0, including address, writedata and loaddata.
- Start is accepted at a clock edge when the state is IDLE or DONE and start=1. The block registers instcode, addr[1:0], storedata and rtold. Start in REQ or RDATA is ignored.
- Let o = addr[1:0].
  - LB/LBU/SB: byteenable = 1<<o.
  - LH/LHU/SH: o must be 0 or 2; byteenable = 0011 or 1100.
  - LW/SW: o must be 0; byteenable = 1111.
  - LWL/LWR: any o; byteenable = 1111.
- Misaligned LH/LHU/SH/LW/SW: go directly to DONE with misaligned=1. No bus cycle; loaddata unchanged.
- Non-memory instcode (including LUI): go directly to DONE with misaligned=0. No bus cycle; loaddata unchanged.
- REQ: read=1 for loads, write=1 for stores. address, byteenable and writedata are held stable for the whole state.
  - If waitrequest=0 at an edge, the request is accepted. Loads go to RDATA; stores go to DONE.
  - If waitrequest=1, stay in REQ. When TIMEOUT>0 and the stall count reaches TIMEOUT, drop read/write and go to DONE with timeout=1.
- Store write data:
  - SB: storedata[7:0] placed in lane o, other lanes 0.
  - SH: storedata[15:0] placed at lanes o..o+1.
  - SW: storedata.
- RDATA: read=write=0. readdata is captured at the edge into loaddata, aligned as follows, then go to DONE.
  - LB: sign-extend byte o. LBU: zero-extend byte o.
  - LH: sign-extend half at o. LHU: zero-extend half at o.
  - LW: readdata.
  - LWL (m=readdata, r=rtold): o=0 {m[7:0],r[23:0]}; o=1 {m[15:0],r[15:0]}; o=2 {m[23:0],r[7:0]}; o=3 m.
  - LWR: o=0 m; o=1 {r[31:24],m[31:8]}; o=2 {r[31:16],m[31:16]}; o=3 {r[31:8],m[31:24]}.
- DONE lasts exactly one cycle: done=1, busy=0, read=write=0. Next state is IDLE, or REQ/DONE if a new start is accepted. misaligned/timeout are 0 whenever done=0.
- Latency with zero wait states, counted in cycles after the start edge:
  - load: read high in cycle 1, done in cycle 3.
  - store: write high in cycle 1, done in cycle 2.
  - misaligned/non-memory: done in cycle 1.
  - Each waitrequest cycle adds 1.
- Reset asserted in any state: next cycle state IDLE, read=write=0, no done pulse. An in-flight load result is discarded.
- Never assert read and write together. byteenable=0 outside REQ.

Test Plan:
- LB, addr=0x1002, readdata=0x12FE3456, no waits -> address=0x1000, byteenable=0100, read in cycle 1 only, done in cycle 3, loaddata=0xFFFFFFFE.
- SH, addr=0x2002, storedata=0xAAAA1234, waitrequest high 3 cycles -> write held 4 cycles with address=0x2000, byteenable=1100, writedata=0x12340000; done 1 cycle after acceptance.
- LWL/LWR, addr=0x3001, readdata=0x44332211, rtold=0xAABBCCDD -> LWL loaddata=0x2211CCDD; LWR loaddata=0xAA443322.
- LW, addr=0x4002 -> done in cycle 1 with misaligned=1, read never asserted, loaddata unchanged. LUI -> done in cycle 1 with misaligned=0, no bus access.
- TIMEOUT=4, SW with waitrequest stuck high -> write for 4 cycles then dropped, done=1 with timeout=1. Start pulsed while busy -> ignored.
- Reset pulsed while in RDATA -> read=0, no done, loaddata=0. A back-to-back start in the DONE cycle -> REQ entered next cycle.
